// File: rtl/fetch_decode_reg.sv
// Y86-64 fetch stage: PC select, instruction split, valP/predPC, plus the F/D pipeline register.
// F_predPC is held internally; the D register feeds decode and the hazard logic.
module fetch_decode_reg #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            F_stall,
    input  logic            D_stall,
    input  logic            D_bubble,
    input  logic [3:0]      M_icode,
    input  logic            M_cnd,
    input  logic [PC_W-1:0] M_valA,
    input  logic [3:0]      W_icode,
    input  logic [PC_W-1:0] W_valM,
    output logic [PC_W-1:0] f_pc,
    input  logic [79:0]     imem_bytes,
    input  logic            imem_error,
    output logic [2:0]      D_stat,
    output logic [3:0]      D_icode,
    output logic [3:0]      D_ifun,
    output logic [3:0]      D_rA,
    output logic [3:0]      D_rB,
    output logic [PC_W-1:0] D_valC,
    output logic [PC_W-1:0] D_valP
);

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;
    localparam logic [3:0] R_NONE = 4'hF;

    logic [PC_W-1:0] f_pred_pc_q, f_pred_pc_d;

    stat_e           d_stat_q,  d_stat_d;
    logic [3:0]      d_icode_q, d_icode_d;
    logic [3:0]      d_ifun_q,  d_ifun_d;
    logic [3:0]      d_ra_q,    d_ra_d;
    logic [3:0]      d_rb_q,    d_rb_d;
    logic [PC_W-1:0] d_valc_q,  d_valc_d;
    logic [PC_W-1:0] d_valp_q,  d_valp_d;

    logic [3:0]      f_icode, f_ifun, f_ra, f_rb;
    logic            f_valid, need_regids, need_valc;
    logic [63:0]     valc_raw;
    logic [PC_W-1:0] f_valc, f_valp, f_pred_pc;
    stat_e           f_stat;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        f_pc = f_pred_pc_q;
        if (M_icode == I_JXX && !M_cnd) begin
            f_pc = M_valA;
        end else if (W_icode == I_RET) begin
            f_pc = W_valM;
        end

        f_icode = imem_error ? I_NOP  : imem_bytes[7:4];
        f_ifun  = imem_error ? 4'h0   : imem_bytes[3:0];
        f_valid = (f_icode <= 4'hB);

        need_regids = 1'b0;
        case (f_icode)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
            default: need_regids = 1'b0;
        endcase

        need_valc = 1'b0;
        case (f_icode)
            4'h3, 4'h4, 4'h5, I_JXX, I_CALL: need_valc = 1'b1;
            default: need_valc = 1'b0;
        endcase

        f_ra = need_regids ? imem_bytes[15:12] : R_NONE;
        f_rb = need_regids ? imem_bytes[11:8]  : R_NONE;

        // Constant is little-endian and starts after the register byte when present.
        valc_raw = need_regids ? imem_bytes[79:16] : imem_bytes[71:8];
        f_valc   = need_valc ? PC_W'(valc_raw) : '0;

        f_valp = f_pc + PC_W'(1)
               + (need_regids ? PC_W'(1) : '0)
               + (need_valc   ? PC_W'(8) : '0);

        f_pred_pc = (f_icode == I_JXX || f_icode == I_CALL) ? f_valc : f_valp;

        if (imem_error)             f_stat = STAT_ADR;
        else if (!f_valid)          f_stat = STAT_INS;
        else if (f_icode == I_HALT) f_stat = STAT_HLT;
        else                        f_stat = STAT_AOK;

        f_pred_pc_d = F_stall ? f_pred_pc_q : f_pred_pc;

        // Stall takes priority over bubble when hazard logic asserts both.
        d_stat_d  = d_stat_q;
        d_icode_d = d_icode_q;
        d_ifun_d  = d_ifun_q;
        d_ra_d    = d_ra_q;
        d_rb_d    = d_rb_q;
        d_valc_d  = d_valc_q;
        d_valp_d  = d_valp_q;
        if (!D_stall) begin
            if (D_bubble) begin
                d_stat_d  = STAT_AOK;
                d_icode_d = I_NOP;
                d_ifun_d  = 4'h0;
                d_ra_d    = R_NONE;
                d_rb_d    = R_NONE;
                d_valc_d  = '0;
                d_valp_d  = '0;
            end else begin
                d_stat_d  = f_stat;
                d_icode_d = f_icode;
                d_ifun_d  = f_ifun;
                d_ra_d    = f_ra;
                d_rb_d    = f_rb;
                d_valc_d  = f_valc;
                d_valp_d  = f_valp;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            f_pred_pc_q <= RESET_PC;
            d_stat_q    <= STAT_AOK;
            d_icode_q   <= I_NOP;
            d_ifun_q    <= 4'h0;
            d_ra_q      <= R_NONE;
            d_rb_q      <= R_NONE;
            d_valc_q    <= '0;
            d_valp_q    <= '0;
        end else begin
            f_pred_pc_q <= f_pred_pc_d;
            d_stat_q    <= d_stat_d;
            d_icode_q   <= d_icode_d;
            d_ifun_q    <= d_ifun_d;
            d_ra_q      <= d_ra_d;
            d_rb_q      <= d_rb_d;
            d_valc_q    <= d_valc_d;
            d_valp_q    <= d_valp_d;
        end
    end

    assign D_stat  = d_stat_q;
    assign D_icode = d_icode_q;
    assign D_ifun  = d_ifun_q;
    assign D_rA    = d_ra_q;
    assign D_rB    = d_rb_q;
    assign D_valC  = d_valc_q;
    assign D_valP  = d_valp_q;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Table-driven bench for fetch_decode_reg: each vector drives one fetch cycle, checks f_pc,
// and queues the expected D register contents, which are compared after the next clock edge.
module tb_fetch_decode_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        F_stall, D_stall, D_bubble;
    logic [3:0]  M_icode, W_icode;
    logic        M_cnd;
    logic [63:0] M_valA, W_valM;
    logic [63:0] f_pc;
    logic [79:0] imem_bytes;
    logic        imem_error;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;

    fetch_decode_reg #(.PC_W(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset_n(reset_n),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM),
        .f_pc(f_pc), .imem_bytes(imem_bytes), .imem_error(imem_error),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } dexp_t;

    typedef struct {
        logic [79:0] bytes;
        logic        ierr;
        logic [3:0]  m_icode;
        logic        m_cnd;
        logic [63:0] m_vala;
        logic [3:0]  w_icode;
        logic [63:0] w_valm;
        logic        fs, ds, db;
        logic [63:0] exp_pc;
        dexp_t       exp_d;
    } vec_t;

    localparam int NVEC = 16;
    vec_t  vecs[NVEC];
    dexp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic dexp_t mkd(input logic [2:0] s, input logic [3:0] ic, input logic [3:0] fn,
                                  input logic [3:0] a, input logic [3:0] b,
                                  input logic [63:0] c, input logic [63:0] p);
        dexp_t d;
        d.stat = s; d.icode = ic; d.ifun = fn; d.ra = a; d.rb = b; d.valc = c; d.valp = p;
        return d;
    endfunction

    function automatic vec_t mv(input logic [79:0] b, input logic ie,
                                input logic [3:0] mi, input logic mc, input logic [63:0] ma,
                                input logic [3:0] wi, input logic [63:0] wm,
                                input logic fs, input logic ds, input logic db,
                                input logic [63:0] pc, input dexp_t d);
        vec_t v;
        v.bytes = b; v.ierr = ie; v.m_icode = mi; v.m_cnd = mc; v.m_vala = ma;
        v.w_icode = wi; v.w_valm = wm; v.fs = fs; v.ds = ds; v.db = db;
        v.exp_pc = pc; v.exp_d = d;
        return v;
    endfunction

    task automatic check_d(input string tag);
        dexp_t e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".stat"},  D_stat,  e.stat);
        check({tag, ".icode"}, D_icode, e.icode);
        check({tag, ".ifun"},  D_ifun,  e.ifun);
        check({tag, ".rA"},    D_rA,    e.ra);
        check({tag, ".rB"},    D_rB,    e.rb);
        check({tag, ".valC"},  D_valC,  e.valc);
        check({tag, ".valP"},  D_valP,  e.valp);
    endtask

    task automatic drive_idle();
        F_stall = 0; D_stall = 0; D_bubble = 0;
        M_icode = 4'h0; M_cnd = 0; M_valA = '0;
        W_icode = 4'h0; W_valM = '0;
        imem_bytes = '0; imem_error = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        dexp_t bub, held;
        bub = mkd(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        held = mkd(3'd4, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51);

        // irmovq $10,%rdx at 0
        vecs[0]  = mv(80'h0000_0000_0000_000A_F230, 0, 4'h0, 0, 64'h0, 4'h0, 64'h0, 0, 0, 0,
                      64'h0,   mkd(3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10));
        vecs[1]  = mv(80'h0000_0000_0000_0000_2070, 0, 4'h0, 0, 64'h0, 4'h0, 64'h0, 0, 0, 0,
                      64'hA,   mkd(3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'h13));
        vecs[2]  = mv(80'h0000_0000_0000_0001_0071, 0, 4'h0, 0, 64'h0, 4'h0, 64'h0, 0, 0, 0,
                      64'h20,  mkd(3'd1, 4'h7, 4'h1, 4'hF, 4'hF, 64'h100, 64'h29));
        vecs[3]  = mv(80'h0000_0000_0000_0000_0010, 0, 4'h0, 0, 64'h0, 4'h0, 64'h0, 0, 0, 0,
                      64'h100, mkd(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h101));
        // mispredicted jle resolves: fetch from fall-through 0x29
        vecs[4]  = mv(80'h0000_0000_0000_0000_0160, 0, 4'h7, 0, 64'h29, 4'h0, 64'h0, 0, 0, 0,
                      64'h29,  mkd(3'd1, 4'h6, 4'h0, 4'h0, 4'h1, 64'h0, 64'h2B));
        vecs[5]  = mv(80'h0000_0000_0000_0000_0000, 0, 4'h7, 0, 64'h40, 4'h9, 64'h50, 0, 0, 0,
                      64'h40,  mkd(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41));
        vecs[6]  = mv(80'h0000_0000_0000_0000_00C0, 0, 4'h7, 1, 64'h40, 4'h9, 64'h50, 0, 0, 0,
                      64'h50,  held);
        vecs[7]  = mv(80'h0000_0000_0000_000A_F230, 0, 4'h0, 0, 64'h0, 4'h0, 64'h0, 1, 1, 0,
                      64'h51,  held);
        vecs[8]  = mv(80'h0000_0000_0000_000A_F230, 0, 4'h0, 0, 64'h0, 4'h0, 64'h0, 1, 1, 0,
                      64'h51,  held);
        vecs[9]  = mv(80'h0000_0000_0000_000A_F230, 0, 4'h0, 0, 64'h0, 4'h0, 64'h0, 1, 1, 1,
                      64'h51,  held);
        vecs[10] = mv(80'h0000_0000_0000_000A_F230, 0, 4'h0, 0, 64'h0, 4'h0, 64'h0, 1, 0, 1,
                      64'h51,  bub);
        vecs[11] = mv(80'h0000_0000_0000_000A_F230, 1, 4'h0, 0, 64'h0, 4'h0, 64'h0, 0, 0, 0,
                      64'h51,  mkd(3'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h52));
        vecs[12] = mv(80'h1122_3344_5566_7788_2350, 0, 4'h0, 0, 64'h0, 4'h0, 64'h0, 0, 0, 0,
                      64'h52,  mkd(3'd1, 4'h5, 4'h0, 4'h2, 4'h3, 64'h1122334455667788, 64'h5C));
        // nop at the top of the address space: valP wraps to 0
        vecs[13] = mv(80'h0000_0000_0000_0000_0010, 0, 4'h7, 0, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 64'h0, 0, 0, 0,
                      64'hFFFF_FFFF_FFFF_FFFF, mkd(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0));
        vecs[14] = mv(80'h0000_0000_0000_0012_3480, 0, 4'h0, 0, 64'h0, 4'h0, 64'h0, 0, 0, 0,
                      64'h0,   mkd(3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h1234, 64'h9));
        vecs[15] = mv(80'h0000_0000_0000_0000_0090, 0, 4'h0, 0, 64'h0, 4'h0, 64'h0, 0, 0, 0,
                      64'h1234, mkd(3'd1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1235));

        drive_idle();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(bub);
        check_d("reset");
        check("reset.f_pc", f_pc, 64'h0);

        @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < NVEC; i++) begin
            imem_bytes = vecs[i].bytes;  imem_error = vecs[i].ierr;
            M_icode = vecs[i].m_icode;   M_cnd = vecs[i].m_cnd;  M_valA = vecs[i].m_vala;
            W_icode = vecs[i].w_icode;   W_valM = vecs[i].w_valm;
            F_stall = vecs[i].fs;        D_stall = vecs[i].ds;   D_bubble = vecs[i].db;
            #1;
            check($sformatf("v%0d.f_pc", i), f_pc, vecs[i].exp_pc);
            exp_q.push_back(vecs[i].exp_d);
            @(posedge clk);
            #1;
            check_d($sformatf("v%0d", i));
            @(negedge clk);
        end

        // Reset while stall and bubble are both asserted: reset wins, fetch restarts at 0.
        drive_idle();
        reset_n = 0; F_stall = 1; D_stall = 1; D_bubble = 1;
        #1;
        check("rst_mid.f_pc_before", f_pc, 64'h1235);
        exp_q.push_back(bub);
        @(posedge clk);
        #1;
        check_d("rst_mid");
        @(negedge clk);
        drive_idle();
        reset_n = 1;
        imem_bytes = 80'h0000_0000_0000_0000_0010;
        #1;
        check("rst_mid.f_pc_after", f_pc, 64'h0);
        exp_q.push_back(mkd(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1));
        @(posedge clk);
        #1;
        check_d("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
